dcache_store_wb: RTL

DCACHE_STORE_WB -- requirements
Module: dcache_store_wb

---
 rtl/dcache_store_wb_pkg.sv | 49 ++++
 rtl/dcache_store_wb_if.sv | 22 ++
 rtl/dcache_store_wb_fifo.sv | 76 +++++++
 rtl/dcache_store_wb.sv | 118 +++++++++++
 4 files changed

// File: rtl/dcache_store_wb_pkg.sv
// Shared types for the data-cache store write buffer: retired-store and
// completion packets, write-buffer entry, bus command/size and FSM encodings.
package dcache_store_wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned N_WAY      = 2;
  localparam int unsigned N_WR_PORTS = 2;
  localparam int unsigned POS_W      = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } MEM_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } WB_STATE;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  address;
    logic [XLEN-1:0]  data;
    MEM_SIZE          size;
    logic [POS_W-1:0] store_pos;
  } STORE_PACKET_RET;

  typedef struct packed {
    logic             valid;
    logic [POS_W-1:0] store_pos;
  } STORE_PACKET_EX_STAGE;

  typedef struct packed {
    logic [XLEN-1:0]  address;
    logic [XLEN-1:0]  data;
    MEM_SIZE          size;
    logic [POS_W-1:0] store_pos;
  } WB_ENTRY;

endpackage

// File: rtl/dcache_store_wb_if.sv
// Processor-to-memory store bus: command/address/data/size out, accept and
// completion tags back.
interface dcache_store_wb_if;
  import dcache_store_wb_pkg::*;

  BUS_COMMAND      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [XLEN-1:0] proc2mem_data;
  MEM_SIZE         proc2mem_size;
  logic [3:0]      mem2proc_response;
  logic [3:0]      mem2proc_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    input  mem2proc_response, mem2proc_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    output mem2proc_response, mem2proc_tag
  );
endinterface

// File: rtl/dcache_store_wb_fifo.sv
// Circular write buffer: up to LANES enqueues per cycle in lane order, one pop,
// registered free count and sticky overflow for lanes that found no room.
module wb_fifo
  import dcache_store_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LANES = N_WAY
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [LANES-1:0]         enq_valid,
  input  WB_ENTRY                  enq_entry [LANES],
  input  logic                     pop,
  output WB_ENTRY                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   free_cnt,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  WB_ENTRY        mem [DEPTH];
  logic [PW-1:0]  head_ptr, tail_ptr;
  logic [CW-1:0]  space, n_acc, count_next;
  logic [LANES-1:0] acc;
  logic [PW-1:0]  wr_idx [LANES];
  logic           drop;

  // A slot freed by this cycle's pop is already usable by this cycle's lanes.
  always_comb begin
    space = CW'(DEPTH) - count + CW'(pop);
    n_acc = '0;
    acc   = '0;
    drop  = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      wr_idx[i] = tail_ptr + n_acc[PW-1:0];
      if (enq_valid[i]) begin
        if (n_acc < space) begin
          acc[i] = 1'b1;
          n_acc  = n_acc + CW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
    count_next = count + n_acc - CW'(pop);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (acc[i]) mem[wr_idx[i]] <= enq_entry[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      free_cnt <= CW'(DEPTH);
      overflow <= 1'b0;
    end else begin
      tail_ptr <= tail_ptr + n_acc[PW-1:0];
      if (pop) head_ptr <= head_ptr + PW'(1);
      count    <= count_next;
      free_cnt <= CW'(DEPTH) - count_next;
      if (drop) overflow <= 1'b1;
    end
  end

  assign head = mem[head_ptr];

endmodule

// File: rtl/dcache_store_wb.sv
// Store write buffer: retires stores into wb_fifo, issues them one at a time to
// memory with a write-through cache update. Optional macro: STORE_WB_BYPASS_EN.
module dcache_store_wb
  import dcache_store_wb_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  STORE_PACKET_RET      [N_WAY-1:0]       store_ret_packet_in,
  output logic                 [$clog2(WB_DEPTH):0] wb_free_cnt,
  dcache_store_wb_if.master                      mem,
  output logic                                   dc_wr_en,
  output logic                 [XLEN-1:0]        dc_wr_addr,
  output logic                 [XLEN-1:0]        dc_wr_data,
  output MEM_SIZE                                dc_wr_size,
  output STORE_PACKET_EX_STAGE [N_WR_PORTS-1:0]  store_packet_dcache,
  output logic                                   wb_overflow
);

  WB_STATE          state, state_next;
  logic [3:0]       lat_tag;
  logic             tag_load, pop, bypass_hit;
  logic             comp_valid;
  logic [POS_W-1:0] comp_pos;
  logic [N_WAY-1:0] enq_valid;
  WB_ENTRY          enq_entry [N_WAY];
  WB_ENTRY          head;
  logic [$clog2(WB_DEPTH):0] fifo_count;

  always_comb begin
    for (int unsigned i = 0; i < N_WAY; i++) begin
      enq_valid[i] = store_ret_packet_in[i].valid;
      enq_entry[i] = '{address:   store_ret_packet_in[i].address,
                       data:      store_ret_packet_in[i].data,
                       size:      store_ret_packet_in[i].size,
                       store_pos: store_ret_packet_in[i].store_pos};
    end
  end

  wb_fifo #(.DEPTH(WB_DEPTH), .LANES(N_WAY)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_entry (enq_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .free_cnt  (wb_free_cnt),
    .overflow  (wb_overflow)
  );

`ifdef STORE_WB_BYPASS_EN
  assign bypass_hit = (fifo_count == '0) && store_ret_packet_in[0].valid;
`else
  assign bypass_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      lat_tag    <= '0;
      comp_valid <= 1'b0;
      comp_pos   <= '0;
    end else begin
      state      <= state_next;
      if (tag_load) lat_tag <= mem.mem2proc_response;
      comp_valid <= pop;
      comp_pos   <= pop ? head.store_pos : '0;
    end
  end

  always_comb begin
    state_next           = state;
    tag_load             = 1'b0;
    pop                  = 1'b0;
    dc_wr_en             = 1'b0;
    dc_wr_addr           = '0;
    dc_wr_data           = '0;
    dc_wr_size           = BYTE;
    mem.proc2mem_command = BUS_NONE;
    mem.proc2mem_addr    = '0;
    mem.proc2mem_data    = '0;
    mem.proc2mem_size    = BYTE;
    case (state)
      IDLE: begin
        if (fifo_count != '0 || bypass_hit) state_next = ISSUE;
      end
      ISSUE: begin
        mem.proc2mem_command = BUS_STORE;
        mem.proc2mem_addr    = head.address;
        mem.proc2mem_data    = head.data;
        mem.proc2mem_size    = head.size;
        if (mem.mem2proc_response != '0) begin
          tag_load   = 1'b1;
          dc_wr_en   = 1'b1;
          dc_wr_addr = head.address;
          dc_wr_data = head.data;
          dc_wr_size = head.size;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem.mem2proc_tag != '0 && mem.mem2proc_tag == lat_tag) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    store_packet_dcache    = '0;
    store_packet_dcache[0] = '{valid: comp_valid, store_pos: comp_pos};
  end

endmodule
